// File: rtl/operand_normalizer_pkg.sv
// rtl/operand_normalizer_pkg.sv - shared widths, state encoding and helpers for the operand normalizer
package operand_normalizer_pkg;

  localparam int IN_W      = 16;
  localparam int OUT_W     = 8;
  localparam int CNT_W     = 4;
  localparam int MAX_SHIFT = IN_W - OUT_W;

  // 2'b11 is unreachable in normal operation and is decoded as IDLE
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  typedef logic [IN_W-1:0]  operand_t;
  typedef logic [OUT_W-1:0] norm_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic norm_t top_bits(input operand_t v);
    return v[IN_W-1:IN_W-OUT_W];
  endfunction

endpackage

// File: rtl/operand_normalizer_if.sv
// rtl/operand_normalizer_if.sv - request/result bundle between a requester and the operand normalizer
interface operand_normalizer_if;
  import operand_normalizer_pkg::*;

  logic     start;
  operand_t data_in;
  logic     busy;
  logic     done;
  norm_t    norm_out;
  cnt_t     shift_cnt;
  logic     zero;

  modport master (
    output start, data_in,
    input  busy, done, norm_out, shift_cnt, zero
  );

  modport slave (
    input  start, data_in,
    output busy, done, norm_out, shift_cnt, zero
  );

endinterface

// File: rtl/operand_normalizer_norm_shift_reg.sv
// rtl/operand_normalizer_norm_shift_reg.sv - loadable left shifter with zero fill; clr > ld > sh
module norm_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (sh) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/operand_normalizer.sv
// rtl/operand_normalizer.sv - shifts an operand left until MSB=1 or the cap, reports top bits and shift count
module operand_normalizer
  import operand_normalizer_pkg::*;
(
  input logic                clk,
  input logic                rst,
  operand_normalizer_if.slave bus
);

  logic [1:0] state;
  logic [1:0] state_next;
  operand_t   work;
  cnt_t       cnt;
  logic       zero_q;
  logic       ld;
  logic       sh;
  logic       at_cap;
  logic       stop;

  // MSB and cap are evaluated together; either ends the shifting
  always_comb begin
    at_cap     = (cnt == cnt_t'(MAX_SHIFT));
    stop       = work[IN_W-1] | at_cap;
    ld         = 1'b0;
    sh         = 1'b0;
    state_next = state;
    case (state)
      ST_SHIFT: begin
        if (stop) begin
          state_next = ST_DONE;
        end else begin
          sh = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        if (bus.start) begin
          ld         = 1'b1;
          state_next = ST_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      zero_q <= 1'b0;
    end else if (ld) begin
      cnt    <= '0;
      zero_q <= (bus.data_in == '0);
    end else if (sh) begin
      cnt    <= cnt + cnt_t'(1);
    end
  end

  norm_shift_reg #(
    .W (IN_W)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .ld  (ld),
    .sh  (sh),
    .d   (bus.data_in),
    .q   (work)
  );

  assign bus.busy      = (state == ST_SHIFT);
  assign bus.done      = (state == ST_DONE);
  assign bus.norm_out  = top_bits(work);
  assign bus.shift_cnt = cnt;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_operand_normalizer.sv
// tb/tb_operand_normalizer.sv - directed and randomized self-checking bench for operand_normalizer
module tb_operand_normalizer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  operand_normalizer_if bus ();

  operand_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: leading-zero count capped at 8, then take the top byte of the shifted value
  task automatic model(input logic [15:0] d, output int k, output logic [7:0] n, output logic z);
    int          lz;
    logic [15:0] s;
    lz = 16;
    for (int b = 0; b < 16; b++) if (d[b]) lz = 15 - b;
    k = (lz > 8) ? 8 : lz;
    s = d << k;
    n = s[15:8];
    z = (d == 16'h0000);
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done || cyc >= 30) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] d);
    int         k;
    logic [7:0] n;
    logic       z;
    int         cyc;
    int         bc;
    model(d, k, n, z);
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = d;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.data_in = $urandom;
    wait_done(cyc, bc);
    check({tag, "_latency"}, cyc, k + 2);
    check({tag, "_busy_cycles"}, bc, k + 1);
    check({tag, "_norm"}, bus.norm_out, n);
    check({tag, "_cnt"}, bus.shift_cnt, k);
    check({tag, "_zero"}, bus.zero, z);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_norm_hold"}, bus.norm_out, n);
  endtask

  initial begin
    int          cyc;
    int          bc;
    logic [15:0] r;
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_in = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_norm", bus.norm_out, 8'h00);
    check("rst_cnt", bus.shift_cnt, 4'h0);
    check("rst_zero", bus.zero, 1'b0);
    rst = 1'b0;

    run_op("msb_set", 16'h8001);
    run_op("seven", 16'h0123);
    run_op("cap_small", 16'h0005);
    run_op("all_zero", 16'h0000);
    run_op("ones", 16'hFFFF);
    run_op("just_below", 16'h00FF);
    run_op("just_at", 16'h0100);

    // starts during SHIFT and DONE are ignored; a held start is taken on the first IDLE edge
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = 16'h0040;
    @(negedge clk);
    bus.data_in = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 2;
    while (!bus.done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_latency", cyc, 10);
    check("ign_norm", bus.norm_out, 8'h40);
    check("ign_cnt", bus.shift_cnt, 4'h8);
    bus.start = 1'b1;
    bus.data_in = 16'hFFFF;
    @(negedge clk);
    check("ign_done_busy", bus.busy, 1'b0);
    check("ign_done_norm", bus.norm_out, 8'h40);
    @(negedge clk);
    check("held_accept", bus.busy, 1'b1);
    bus.start = 1'b0;
    @(negedge clk);
    check("held_done", bus.done, 1'b1);
    check("held_norm", bus.norm_out, 8'hFF);
    check("held_cnt", bus.shift_cnt, 4'h0);

    // asynchronous reset between edges, mid-shift
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = 16'h0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_norm", bus.norm_out, 8'h00);
    check("arst_cnt", bus.shift_cnt, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 16'h1000);

    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom) >> $urandom_range(0, 16);
      run_op("rand", r);
    end

    wait_done(cyc, bc);
    check("idle_no_done", cyc, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
